fetch_line_buffer: RTL

- Sits between the 128-bit instruction RAM port of my_wrapper and the core's decode stage.
- Fetches one aligned 16-byte line, holds it in a single-entry buffer, and hands 32-bit instructions to decode with a valid/ready handshake.
- Handles redirects from branch, trap, ecall/ebreak and mret, including discarding stale in-flight line returns, plus a fence.i flush.

---
 rtl/fetch_line_buffer_pkg.sv | 18 +
 rtl/fetch_word_sel.sv | 24 ++
 rtl/fetch_line_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_line_buffer_pkg.sv
// Shared constants and state encoding for the instruction fetch line buffer
// and the data-side load path that reuses the word selector.
package fetch_line_buffer_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WORD_SEL_W     = 2;
  localparam int unsigned WORD_SEL_LSB   = 2;
  localparam int unsigned TAG_LSB        = 4;

  typedef enum logic [1:0] {
    S_MISS = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_word_sel.sv
// Combinational selection of one 32-bit word out of a 4-word line.
module fetch_word_sel
  import fetch_line_buffer_pkg::*;
#(
  parameter int unsigned LINE_W = 128
) (
  input  logic [LINE_W-1:0]                line_i,
  input  logic [WORD_SEL_W-1:0]            sel_i,
  output logic [LINE_W/WORDS_PER_LINE-1:0] word_c
);

  localparam int unsigned W = LINE_W / WORDS_PER_LINE;

  always_comb begin
    word_c = line_i[0 +: W];
    case (sel_i)
      2'd1:    word_c = line_i[W +: W];
      2'd2:    word_c = line_i[2*W +: W];
      2'd3:    word_c = line_i[3*W +: W];
      default: word_c = line_i[0 +: W];
    endcase
  end

endmodule

// File: rtl/fetch_line_buffer.sv
// Single-entry instruction line buffer between the 128-bit instruction RAM
// and decode, with redirect handling, stale-return discard and fence.i flush.
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       LINE_W   = 128,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              flush_i,
  output logic              instr_valid_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  localparam int unsigned TAG_W = ADDR_W - TAG_LSB;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              line_valid_q, line_valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              hit_c;
  logic              fire_c;
  logic [ADDR_W-1:0] target_c;

  assign hit_c         = line_valid_q && (tag_q == pc_q[ADDR_W-1:TAG_LSB]);
  assign instr_valid_o = (state_q == S_RUN) && hit_c;
  assign fire_c        = instr_valid_o && instr_ready_i;
  assign target_c      = redirect_pc_i & ~ADDR_W'(3);

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign instr_pc_o = pc_q;

  fetch_word_sel #(
    .LINE_W (LINE_W)
  ) u_word_sel (
    .line_i (line_q),
    .sel_i  (pc_q[TAG_LSB-1:WORD_SEL_LSB]),
    .word_c (instr_o)
  );

  // Next-state: per-state fetch sequencing, then redirect/flush overrides.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    line_d       = line_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      S_MISS: begin
        if (redirect_i || flush_i) begin
          state_d = S_RUN;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_q[ADDR_W-1:TAG_LSB], {TAG_LSB{1'b0}}};
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          line_d       = mem_rdata_i;
          tag_d        = mem_addr_q[ADDR_W-1:TAG_LSB];
          line_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = S_RUN;
        end else if (redirect_i || flush_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (fire_c) begin
          pc_d = pc_q + ADDR_W'(4);
        end
        if (redirect_i || flush_i) begin
          state_d = S_RUN;
        end else if (!hit_c) begin
          state_d = S_MISS;
        end
      end
      default: state_d = S_MISS;
    endcase

    // A flush also invalidates a line captured in the same cycle.
    if (flush_i) begin
      line_valid_d = 1'b0;
    end
    if (redirect_i) begin
      pc_d = target_c;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_MISS;
      pc_q         <= RESET_PC;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      line_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule
